// File: rtl/pipe_ctrl_unit.sv
// Centralised control for the 5-stage MIPS pipeline: D-stage decode, E/M/W
// control registers, Tuse/Tnew stall detection and operand forwarding selects.
module pipe_ctrl_unit #(
    parameter int RA_W     = 5,
    parameter int LINK_REG = 31,
    parameter bit EN_SLT   = 1'b1,
    parameter bit EN_JR    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_D,
    output logic            stall,
    output logic            ext_op_D,
    output logic [1:0]      npc_sel_D,
    output logic [1:0]      fwd_rs_D,
    output logic [1:0]      fwd_rt_D,
    output logic [1:0]      fwd_rs_E,
    output logic [1:0]      fwd_rt_E,
    output logic            fwd_rt_M,
    output logic [1:0]      alu_op_E,
    output logic            bsel_E,
    output logic            lui_E,
    output logic            dm_wr_M,
    output logic            rf_wr_W,
    output logic [1:0]      wd_sel_W,
    output logic [RA_W-1:0] wa_W
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic [1:0]      alu_op;
        logic            bsel;
        logic            lui;
        logic            dm_wr;
        logic            rf_wr;
        logic [1:0]      wd_sel;
        logic [RA_W-1:0] wa;
        logic [1:0]      tnew;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
    } ctl_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A producer still computing its result when the consumer needs it.
    function automatic logic pending(input logic wr, input logic [RA_W-1:0] wa,
                                     input logic [1:0] tnew, input logic [RA_W-1:0] r,
                                     input logic [1:0] tuse);
        return wr && (r != '0) && (wa == r) && (tnew > tuse);
    endfunction

    function automatic logic ready(input logic wr, input logic [RA_W-1:0] wa,
                                   input logic [1:0] tnew, input logic [RA_W-1:0] r);
        return wr && (wa != '0) && (wa == r) && (tnew == 2'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic young, input logic old);
        return young ? 2'd1 : (old ? 2'd2 : 2'd0);
    endfunction

    logic [5:0]      op, fn;
    logic [RA_W-1:0] rs_f, rt_f, rd_f;
    logic            rd_rs, rd_rt;
    logic [1:0]      tuse_rs_D, tuse_rt_D;
    ctl_t            dec_D, e_d, e_q;
    logic            m_rf_wr_q, m_dm_wr_q;
    logic [1:0]      m_wd_sel_q, m_tnew_q;
    logic [RA_W-1:0] m_wa_q, m_rt_q;
    logic            w_rf_wr_q;
    logic [1:0]      w_wd_sel_q;
    logic [RA_W-1:0] w_wa_q;
    logic            unused_shamt;

    assign op   = instr_D[31:26];
    assign fn   = instr_D[5:0];
    assign rs_f = RA_W'(instr_D[25:21]);
    assign rt_f = RA_W'(instr_D[20:16]);
    assign rd_f = RA_W'(instr_D[15:11]);
    // No decoded instruction uses the shift amount.
    assign unused_shamt = ^instr_D[10:6];

    always_comb begin
        dec_D     = '0;
        ext_op_D  = 1'b0;
        npc_sel_D = 2'd0;
        rd_rs     = 1'b0;
        rd_rt     = 1'b0;
        tuse_rs_D = 2'd0;
        tuse_rt_D = 2'd0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        dec_D.rf_wr  = 1'b1;
                        dec_D.wa     = rd_f;
                        dec_D.tnew   = 2'd1;
                        dec_D.alu_op = (fn == FN_SUBU) ? 2'd1 : 2'd0;
                        rd_rs = 1'b1; tuse_rs_D = 2'd1;
                        rd_rt = 1'b1; tuse_rt_D = 2'd1;
                    end
                    FN_SLT: if (EN_SLT) begin
                        dec_D.rf_wr  = 1'b1;
                        dec_D.wa     = rd_f;
                        dec_D.tnew   = 2'd1;
                        dec_D.alu_op = 2'd3;
                        rd_rs = 1'b1; tuse_rs_D = 2'd1;
                        rd_rt = 1'b1; tuse_rt_D = 2'd1;
                    end
                    FN_JR: if (EN_JR) begin
                        npc_sel_D = 2'd3;
                        rd_rs     = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec_D.alu_op = 2'd2;
                dec_D.bsel   = 1'b1;
                dec_D.rf_wr  = 1'b1;
                dec_D.wa     = rt_f;
                dec_D.tnew   = 2'd1;
                rd_rs = 1'b1; tuse_rs_D = 2'd1;
            end
            OP_LW: begin
                ext_op_D     = 1'b1;
                dec_D.bsel   = 1'b1;
                dec_D.rf_wr  = 1'b1;
                dec_D.wd_sel = 2'd1;
                dec_D.wa     = rt_f;
                dec_D.tnew   = 2'd2;
                rd_rs = 1'b1; tuse_rs_D = 2'd1;
            end
            OP_SW: begin
                ext_op_D    = 1'b1;
                dec_D.bsel  = 1'b1;
                dec_D.dm_wr = 1'b1;
                rd_rs = 1'b1; tuse_rs_D = 2'd1;
                rd_rt = 1'b1; tuse_rt_D = 2'd2;
            end
            OP_BEQ: begin
                npc_sel_D = 2'd1;
                rd_rs     = 1'b1;
                rd_rt     = 1'b1;
            end
            OP_LUI: begin
                dec_D.lui   = 1'b1;
                dec_D.rf_wr = 1'b1;
                dec_D.wa    = rt_f;
                dec_D.tnew  = 2'd1;
            end
            OP_J:    npc_sel_D = 2'd2;
            OP_JAL: begin
                npc_sel_D    = 2'd2;
                dec_D.rf_wr  = 1'b1;
                dec_D.wd_sel = 2'd2;
                dec_D.wa     = RA_W'(LINK_REG);
            end
            default: ;
        endcase
        // Unread source fields are zeroed so they can never stall or forward.
        dec_D.rs = rd_rs ? rs_f : '0;
        dec_D.rt = rd_rt ? rt_f : '0;
    end

    assign stall = pending(e_q.rf_wr, e_q.wa, e_q.tnew, dec_D.rs, tuse_rs_D)
                 | pending(m_rf_wr_q, m_wa_q, m_tnew_q, dec_D.rs, tuse_rs_D)
                 | pending(e_q.rf_wr, e_q.wa, e_q.tnew, dec_D.rt, tuse_rt_D)
                 | pending(m_rf_wr_q, m_wa_q, m_tnew_q, dec_D.rt, tuse_rt_D);

    assign e_d = stall ? '0 : dec_D;

    assign fwd_rs_D = fwd_sel(ready(e_q.rf_wr, e_q.wa, e_q.tnew, dec_D.rs),
                              ready(m_rf_wr_q, m_wa_q, m_tnew_q, dec_D.rs));
    assign fwd_rt_D = fwd_sel(ready(e_q.rf_wr, e_q.wa, e_q.tnew, dec_D.rt),
                              ready(m_rf_wr_q, m_wa_q, m_tnew_q, dec_D.rt));
    assign fwd_rs_E = fwd_sel(ready(m_rf_wr_q, m_wa_q, m_tnew_q, e_q.rs),
                              ready(w_rf_wr_q, w_wa_q, 2'd0, e_q.rs));
    assign fwd_rt_E = fwd_sel(ready(m_rf_wr_q, m_wa_q, m_tnew_q, e_q.rt),
                              ready(w_rf_wr_q, w_wa_q, 2'd0, e_q.rt));
    assign fwd_rt_M = ready(w_rf_wr_q, w_wa_q, 2'd0, m_rt_q);

    // D -> E -> M -> W control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= '0;
            m_rf_wr_q  <= 1'b0;
            m_dm_wr_q  <= 1'b0;
            m_wd_sel_q <= 2'd0;
            m_tnew_q   <= 2'd0;
            m_wa_q     <= '0;
            m_rt_q     <= '0;
            w_rf_wr_q  <= 1'b0;
            w_wd_sel_q <= 2'd0;
            w_wa_q     <= '0;
        end else begin
            e_q        <= e_d;
            m_rf_wr_q  <= e_q.rf_wr;
            m_dm_wr_q  <= e_q.dm_wr;
            m_wd_sel_q <= e_q.wd_sel;
            m_tnew_q   <= tnew_dec(e_q.tnew);
            m_wa_q     <= e_q.wa;
            m_rt_q     <= e_q.rt;
            w_rf_wr_q  <= m_rf_wr_q;
            w_wd_sel_q <= m_wd_sel_q;
            w_wa_q     <= m_wa_q;
        end
    end

    assign alu_op_E = e_q.alu_op;
    assign bsel_E   = e_q.bsel;
    assign lui_E    = e_q.lui;
    assign dm_wr_M  = m_dm_wr_q;
    assign rf_wr_W  = w_rf_wr_q;
    assign wd_sel_W = w_wd_sel_q;
    assign wa_W     = w_wa_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed hazard scenarios plus randomized streams
// checked against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;
    typedef enum int {M_NOP, M_ADDU, M_SUBU, M_SLT, M_JR, M_ORI, M_LW, M_SW,
                      M_BEQ, M_LUI, M_J, M_JAL} mn_t;
    typedef struct { mn_t mn; int rs; int rt; int rd; } rec_t;
    typedef struct packed {
        logic stall; logic ext; logic [1:0] npc;
        logic [1:0] frs_d; logic [1:0] frt_d; logic [1:0] frs_e; logic [1:0] frt_e;
        logic frt_m; logic [1:0] alu; logic bsel; logic lui; logic dmwr; logic rfwr;
        logic [1:0] wdsel; logic [4:0] wa;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] instr0, instr1;
    logic stall0, ext0, frtM0, bsel0, lui0, dmwr0, rfwr0;
    logic [1:0] npc0, frsD0, frtD0, frsE0, frtE0, alu0, wdsel0;
    logic [4:0] wa0;
    logic stall1, ext1, frtM1, bsel1, lui1, dmwr1, rfwr1;
    logic [1:0] npc1, frsD1, frtD1, frsE1, frtE1, alu1, wdsel1;
    logic [4:0] wa1;
    obs_t obs [2];
    int n_chk, n_fail;
    rec_t pipe_m [2][3];

    always #5 clk = ~clk;

    pipe_ctrl_unit dut0 (.clk(clk), .reset(reset), .instr_D(instr0), .stall(stall0),
        .ext_op_D(ext0), .npc_sel_D(npc0), .fwd_rs_D(frsD0), .fwd_rt_D(frtD0),
        .fwd_rs_E(frsE0), .fwd_rt_E(frtE0), .fwd_rt_M(frtM0), .alu_op_E(alu0),
        .bsel_E(bsel0), .lui_E(lui0), .dm_wr_M(dmwr0), .rf_wr_W(rfwr0),
        .wd_sel_W(wdsel0), .wa_W(wa0));

    pipe_ctrl_unit #(.EN_SLT(1'b0), .EN_JR(1'b0)) dut1 (.clk(clk), .reset(reset),
        .instr_D(instr1), .stall(stall1), .ext_op_D(ext1), .npc_sel_D(npc1),
        .fwd_rs_D(frsD1), .fwd_rt_D(frtD1), .fwd_rs_E(frsE1), .fwd_rt_E(frtE1),
        .fwd_rt_M(frtM1), .alu_op_E(alu1), .bsel_E(bsel1), .lui_E(lui1),
        .dm_wr_M(dmwr1), .rf_wr_W(rfwr1), .wd_sel_W(wdsel1), .wa_W(wa1));

    assign obs[0] = {stall0, ext0, npc0, frsD0, frtD0, frsE0, frtE0, frtM0, alu0,
                     bsel0, lui0, dmwr0, rfwr0, wdsel0, wa0};
    assign obs[1] = {stall1, ext1, npc1, frsD1, frtD1, frsE1, frtE1, frtM1, alu1,
                     bsel1, lui1, dmwr1, rfwr1, wdsel1, wa1};

    // ---------------- instruction encoding and reference model ----------------
    function automatic logic [31:0] enc(mn_t mn, int rs, int rt, int rd);
        logic [4:0] s, t, d;
        logic [15:0] imm;
        s = 5'(rs); t = 5'(rt); d = 5'(rd); imm = 16'($urandom);
        case (mn)
            M_ADDU: return {6'h00, s, t, d, 5'd0, 6'h21};
            M_SUBU: return {6'h00, s, t, d, 5'd0, 6'h23};
            M_SLT:  return {6'h00, s, t, d, 5'd0, 6'h2a};
            M_JR:   return {6'h00, s, 15'd0, 6'h08};
            M_ORI:  return {6'h0d, s, t, imm};
            M_LW:   return {6'h23, s, t, imm};
            M_SW:   return {6'h2b, s, t, imm};
            M_BEQ:  return {6'h04, s, t, imm};
            M_LUI:  return {6'h0f, 5'd0, t, imm};
            M_J:    return {6'h02, 26'($urandom)};
            M_JAL:  return {6'h03, 26'($urandom)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int pick_reg();
        int p;
        p = $urandom_range(0, 4);
        return (p == 4) ? 31 : p;
    endfunction

    function automatic logic [31:0] gen_instr();
        int sel;
        sel = $urandom_range(0, 12);
        if (sel == 12) return 32'($urandom);
        return enc(mn_t'(sel), pick_reg(), pick_reg(), pick_reg());
    endfunction

    function automatic rec_t decode_rec(logic [31:0] ins, bit en_slt, bit en_jr);
        rec_t r;
        r.rs = int'(ins[25:21]); r.rt = int'(ins[20:16]); r.rd = int'(ins[15:11]);
        r.mn = M_NOP;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h21: r.mn = M_ADDU;
                6'h23: r.mn = M_SUBU;
                6'h2a: r.mn = en_slt ? M_SLT : M_NOP;
                6'h08: r.mn = en_jr ? M_JR : M_NOP;
                default: r.mn = M_NOP;
            endcase
            6'h0d: r.mn = M_ORI;
            6'h23: r.mn = M_LW;
            6'h2b: r.mn = M_SW;
            6'h04: r.mn = M_BEQ;
            6'h0f: r.mn = M_LUI;
            6'h02: r.mn = M_J;
            6'h03: r.mn = M_JAL;
            default: r.mn = M_NOP;
        endcase
        return r;
    endfunction

    function automatic rec_t bubble();
        rec_t r;
        r.mn = M_NOP; r.rs = 0; r.rt = 0; r.rd = 0;
        return r;
    endfunction

    function automatic bit writes(mn_t m);
        return m inside {M_ADDU, M_SUBU, M_SLT, M_ORI, M_LW, M_LUI, M_JAL};
    endfunction

    function automatic int dst(rec_t r);
        if (r.mn inside {M_ADDU, M_SUBU, M_SLT}) return r.rd;
        if (r.mn inside {M_ORI, M_LW, M_LUI}) return r.rt;
        if (r.mn == M_JAL) return 31;
        return 0;
    endfunction

    // Cycles until the result exists, for an instruction 'stage' steps past E entry.
    function automatic int tnew_at(mn_t m, int stage);
        int base;
        base = (m == M_LW) ? 2 : ((m inside {M_ADDU, M_SUBU, M_SLT, M_ORI, M_LUI}) ? 1 : 0);
        return (base > stage) ? base - stage : 0;
    endfunction

    function automatic int tuse_rs(mn_t m);
        if (m inside {M_BEQ, M_JR}) return 0;
        if (m inside {M_ADDU, M_SUBU, M_SLT, M_ORI, M_LW, M_SW}) return 1;
        return -1;
    endfunction

    function automatic int tuse_rt(mn_t m);
        if (m == M_BEQ) return 0;
        if (m inside {M_ADDU, M_SUBU, M_SLT}) return 1;
        if (m == M_SW) return 2;
        return -1;
    endfunction

    function automatic int src_rs(rec_t r);
        return (tuse_rs(r.mn) >= 0) ? r.rs : 0;
    endfunction

    function automatic int src_rt(rec_t r);
        return (tuse_rt(r.mn) >= 0) ? r.rt : 0;
    endfunction

    function automatic int youngest(int d, int r, int lo, int hi);
        for (int k = lo; k <= hi; k++)
            if (r != 0 && writes(pipe_m[d][k].mn) && dst(pipe_m[d][k]) == r &&
                tnew_at(pipe_m[d][k].mn, k) == 0) return k;
        return -1;
    endfunction

    function automatic bit model_stall(int d, rec_t x);
        bit s;
        s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (writes(pipe_m[d][k].mn)) begin
                if (src_rs(x) != 0 && dst(pipe_m[d][k]) == src_rs(x) &&
                    tnew_at(pipe_m[d][k].mn, k) > tuse_rs(x.mn)) s = 1'b1;
                if (src_rt(x) != 0 && dst(pipe_m[d][k]) == src_rt(x) &&
                    tnew_at(pipe_m[d][k].mn, k) > tuse_rt(x.mn)) s = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [1:0] sel_of(int k, int young, int old);
        return (k == young) ? 2'd1 : ((k == old) ? 2'd2 : 2'd0);
    endfunction

    function automatic obs_t model_out(int d, rec_t x);
        obs_t o;
        rec_t e, m, w;
        e = pipe_m[d][0]; m = pipe_m[d][1]; w = pipe_m[d][2];
        o = '0;
        o.stall = model_stall(d, x);
        o.ext   = x.mn inside {M_LW, M_SW};
        case (x.mn)
            M_BEQ:      o.npc = 2'd1;
            M_J, M_JAL: o.npc = 2'd2;
            M_JR:       o.npc = 2'd3;
            default:    o.npc = 2'd0;
        endcase
        o.frs_d = sel_of(youngest(d, src_rs(x), 0, 1), 0, 1);
        o.frt_d = sel_of(youngest(d, src_rt(x), 0, 1), 0, 1);
        o.frs_e = sel_of(youngest(d, src_rs(e), 1, 2), 1, 2);
        o.frt_e = sel_of(youngest(d, src_rt(e), 1, 2), 1, 2);
        o.frt_m = youngest(d, src_rt(m), 2, 2) == 2;
        case (e.mn)
            M_SUBU:  o.alu = 2'd1;
            M_ORI:   o.alu = 2'd2;
            M_SLT:   o.alu = 2'd3;
            default: o.alu = 2'd0;
        endcase
        o.bsel  = e.mn inside {M_ORI, M_LW, M_SW};
        o.lui   = e.mn == M_LUI;
        o.dmwr  = m.mn == M_SW;
        o.rfwr  = writes(w.mn);
        o.wdsel = (w.mn == M_LW) ? 2'd1 : ((w.mn == M_JAL) ? 2'd2 : 2'd0);
        o.wa    = 5'(dst(w));
        return o;
    endfunction

    task automatic model_adv(int d, rec_t x, bit stl, bit rst);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe_m[d][k] = bubble();
        end else begin
            pipe_m[d][2] = pipe_m[d][1];
            pipe_m[d][1] = pipe_m[d][0];
            pipe_m[d][0] = stl ? bubble() : x;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        instr0 = 32'h0; instr1 = 32'h0;
        repeat (3) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        instr0 = enc(M_LW, 0, 8, 0);
        tick();
        repeat (2) begin
            tick();
            #2;
            n_chk++;
            if ({alu0, bsel0, lui0, dmwr0, rfwr0, wdsel0, wa0} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_regs: got %h expected 0", {alu0, bsel0, lui0, dmwr0, rfwr0, wdsel0, wa0});
            end
            n_chk++;
            if (stall0 !== 1'b0 || ext0 !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_dstage: stall=%0b ext=%0b expected 0/1", stall0, ext0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        flush();
        instr0 = enc(M_LW, 0, 8, 0);
        tick();
        instr0 = enc(M_ADDU, 8, 8, 9);
        #2;
        n_chk++;
        if (stall0 !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %0b expected 1", stall0); end
        tick();
        #2;
        n_chk++;
        if (stall0 !== 1'b0 || bsel0 !== 1'b0) begin
            n_fail++; $display("FAIL load_use_bubble: stall=%0b bsel_E=%0b expected 0/0", stall0, bsel0);
        end
        tick();
        instr0 = 32'h0;
        #2;
        n_chk++;
        if ({frsE0, frtE0} !== 4'b1010) begin
            n_fail++; $display("FAIL load_use_fwdE: got %b expected 1010", {frsE0, frtE0});
        end
    endtask

    task automatic test_load_branch();
        flush();
        instr0 = enc(M_LW, 0, 8, 0);
        tick();
        instr0 = enc(M_BEQ, 8, 0, 0);
        #2;
        n_chk++;
        if (stall0 !== 1'b1 || npc0 !== 2'd1) begin
            n_fail++; $display("FAIL load_branch_c1: stall=%0b npc=%0d expected 1/1", stall0, npc0);
        end
        tick();
        #2;
        n_chk++;
        if (stall0 !== 1'b1) begin n_fail++; $display("FAIL load_branch_c2: got %0b expected 1", stall0); end
        tick();
        #2;
        n_chk++;
        if (stall0 !== 1'b0 || frsD0 !== 2'd0) begin
            n_fail++; $display("FAIL load_branch_c3: stall=%0b fwd_rs_D=%0d expected 0/0", stall0, frsD0);
        end
    endtask

    task automatic test_alu_alu();
        flush();
        instr0 = enc(M_ADDU, 1, 2, 3);
        tick();
        instr0 = enc(M_SUBU, 3, 3, 4);
        #2;
        n_chk++;
        if (stall0 !== 1'b0) begin n_fail++; $display("FAIL alu_alu_stall: got %0b expected 0", stall0); end
        tick();
        instr0 = 32'h0;
        #2;
        n_chk++;
        if ({frsE0, frtE0, alu0} !== 6'b010101) begin
            n_fail++; $display("FAIL alu_alu_fwd: fwdE/alu got %b expected 010101", {frsE0, frtE0, alu0});
        end
    endtask

    task automatic test_lw_sw();
        flush();
        instr0 = enc(M_LW, 0, 8, 0);
        tick();
        instr0 = enc(M_SW, 1, 8, 0);
        #2;
        n_chk++;
        if (stall0 !== 1'b0) begin n_fail++; $display("FAIL lw_sw_stall: got %0b expected 0", stall0); end
        tick();
        instr0 = 32'h0;
        #2;
        n_chk++;
        if (frtE0 !== 2'd0 || bsel0 !== 1'b1) begin
            n_fail++; $display("FAIL lw_sw_E: fwd_rt_E=%0d bsel=%0b expected 0/1", frtE0, bsel0);
        end
        tick();
        #2;
        n_chk++;
        if (frtM0 !== 1'b1 || dmwr0 !== 1'b1) begin
            n_fail++; $display("FAIL lw_sw_M: fwd_rt_M=%0b dm_wr=%0b expected 1/1", frtM0, dmwr0);
        end
    endtask

    task automatic test_jal_jr();
        flush();
        instr0 = enc(M_JAL, 0, 0, 0);
        #2;
        n_chk++;
        if (npc0 !== 2'd2) begin n_fail++; $display("FAIL jal_npc: got %0d expected 2", npc0); end
        tick();
        instr0 = enc(M_JR, 31, 0, 0);
        #2;
        n_chk++;
        if (stall0 !== 1'b0 || frsD0 !== 2'd1 || npc0 !== 2'd3) begin
            n_fail++; $display("FAIL jr_after_jal: stall=%0b fwd_rs_D=%0d npc=%0d expected 0/1/3", stall0, frsD0, npc0);
        end
        tick();
        instr0 = 32'h0;
        tick();
        #2;
        n_chk++;
        if ({rfwr0, wdsel0, wa0} !== {1'b1, 2'd2, 5'd31}) begin
            n_fail++; $display("FAIL jal_writeback: got %b expected 11011111", {rfwr0, wdsel0, wa0});
        end
    endtask

    task automatic test_zero_reg();
        flush();
        instr0 = enc(M_ORI, 0, 0, 0);
        tick();
        instr0 = enc(M_ADDU, 0, 0, 1);
        #2;
        n_chk++;
        if ({stall0, frsD0, frtD0} !== 5'd0) begin
            n_fail++; $display("FAIL zero_reg_D: got %b expected 00000", {stall0, frsD0, frtD0});
        end
        tick();
        instr0 = 32'h0;
        #2;
        n_chk++;
        if ({frsE0, frtE0} !== 4'd0) begin
            n_fail++; $display("FAIL zero_reg_E: got %b expected 0000", {frsE0, frtE0});
        end
        instr0 = enc(M_SLT, 1, 2, 5);
        instr1 = instr0;
        tick();
        instr0 = 32'h0; instr1 = 32'h0;
        tick();
        tick();
        #2;
        n_chk++;
        if (rfwr0 !== 1'b1 || wa0 !== 5'd5) begin
            n_fail++; $display("FAIL slt_enabled: rf_wr=%0b wa=%0d expected 1/5", rfwr0, wa0);
        end
        n_chk++;
        if (rfwr1 !== 1'b0 || wa1 !== 5'd0) begin
            n_fail++; $display("FAIL slt_disabled: rf_wr=%0b wa=%0d expected 0/0", rfwr1, wa1);
        end
        instr1 = enc(M_JR, 31, 0, 0);
        #2;
        n_chk++;
        if (npc1 !== 2'd0) begin n_fail++; $display("FAIL jr_disabled: npc=%0d expected 0", npc1); end
        instr1 = 32'h0;
    endtask

    task automatic test_reset_in_stall();
        flush();
        instr0 = enc(M_LW, 0, 8, 0);
        tick();
        instr0 = enc(M_BEQ, 8, 0, 0);
        #2;
        n_chk++;
        if (stall0 !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pre: got %0b expected 1", stall0); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        n_chk++;
        if ({stall0, rfwr0, dmwr0, frsD0, frtD0, frsE0, frtE0, frtM0} !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_stall_post: got %b expected 0", {stall0, rfwr0, dmwr0, frsD0, frtD0, frsE0, frtE0, frtM0});
        end
    endtask

    task automatic test_random(int n);
        rec_t x [2];
        obs_t exp_o [2];
        bit rst;
        reset = 1'b1;
        instr0 = 32'h0; instr1 = 32'h0;
        tick();
        for (int d = 0; d < 2; d++) model_adv(d, bubble(), 1'b0, 1'b1);
        reset = 1'b0;
        instr0 = gen_instr(); instr1 = gen_instr();
        repeat (n) begin
            x[0] = decode_rec(instr0, 1'b1, 1'b1);
            x[1] = decode_rec(instr1, 1'b0, 1'b0);
            rst = ($urandom_range(0, 19) == 0);
            reset = rst;
            #2;
            for (int d = 0; d < 2; d++) begin
                exp_o[d] = model_out(d, x[d]);
                n_chk++;
                if (obs[d] !== exp_o[d]) begin
                    n_fail++;
                    $display("FAIL random_dut%0d: got %h expected %h instr %h", d, obs[d], exp_o[d],
                             (d == 0) ? instr0 : instr1);
                end
            end
            tick();
            for (int d = 0; d < 2; d++) model_adv(d, x[d], exp_o[d].stall, rst);
            if (rst || !exp_o[0].stall) instr0 = gen_instr();
            if (rst || !exp_o[1].stall) instr1 = gen_instr();
        end
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        instr0 = 32'h0;
        instr1 = 32'h0;
        tick();
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_alu();
        test_lw_sw();
        test_jal_jr();
        test_zero_reg();
        test_reset_in_stall();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Centralised control for the 5-stage MIPS pipeline (F/D/E/M/W).
- Decodes the D-stage instruction once and carries the control bundle through internal E/M/W pipeline registers.
- Detects Tuse/Tnew data hazards, generating the stall and bubble, and produces operand forwarding selects for the D and E stages.
- Parametrised in register-address width, link register and optional instructions.

Parameters:
- RA_W, 5, register-address width.
- LINK_REG, 31, destination register for jal.
- EN_SLT, 1, decode slt when 1; when 0, slt decodes as nop.
- EN_JR, 1, decode jr when 1; when 0, jr decodes as nop.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all pipeline control registers.
- instr_D  in  32  instruction currently held in the D stage.
- stall  out  1  hold PC and the F/D register, and insert a bubble into E.
- ext_op_D  out  1  sign-extend when 1, zero-extend when 0 (lw, sw).
- npc_sel_D  out  2  next-PC select: 0 = PC+4, 1 = beq, 2 = j/jal, 3 = jr.
- fwd_rs_D, fwd_rt_D  out  2  D-operand source for the comparator/jr: 0 = RF, 1 = E (PC+8), 2 = M.
- fwd_rs_E, fwd_rt_E  out  2  E-operand source for the ALU/DM data: 0 = pipeline register, 1 = M, 2 = W.
- fwd_rt_M  out  1  DM write data taken from W.
- alu_op_E  out  2  0 = add, 1 = sub, 2 = or, 3 = slt.
- bsel_E  out  1  ALU B operand is the immediate.
- lui_E  out  1  result is imm<<16.
- dm_wr_M  out  1  data-memory write enable.
- rf_wr_W  out  1  register-file write enable.
- wd_sel_W  out  2  write data: 0 = ALU, 1 = DM, 2 = PC+8.
- wa_W  out  RA_W  register-file write address.

Behaviour:
- Decode set: addu, subu, ori, lw, sw, beq, lui, j, jal, jr*, slt*.
  - Starred entries are gated by their parameter.
  - Anything else is a nop: all controls 0, wa = 0.
- Destination register:
  - rd for R-type writers.
  - rt for ori, lw, lui.
  - LINK_REG for jal.
  - 0 otherwise.
- Tuse (D-stage view):
  - rs: beq, jr = 0; addu, subu, slt, ori, lw, sw = 1; otherwise none.
  - rt: beq = 0; addu, subu, slt = 1; sw = 2; otherwise none.
- Tnew at entry to E:
  - lw = 2.
  - addu, subu, ori, lui, slt = 1.
  - jal = 0.
  - Decrements by one per stage advance, saturating at 0; carried in the E and M registers.
- Stall condition: stall = 1 when some source reg r≠0 has Tuse, and either:
  - (wa_E==r, rf_wr_E, Tnew_E > Tuse), or
  - (wa_M==r, rf_wr_M, Tnew_M > Tuse).
  - Combinational from instr_D and the E/M registers.
- On stall:
  - The E register loads a bubble (all controls 0, wa 0, Tnew 0).
  - The M and W registers advance normally.
  - Otherwise the E register loads the decoded bundle.
  - M←E and W←M every cycle.
- Forwarding priority is the youngest qualifying stage. A stage qualifies when its rf_wr=1, wa≠0, wa==r and Tnew==0.
  - fwd_*_D: E (jal only) beats M; W is covered by the RF internal bypass.
  - fwd_*_E: M beats W.
  - fwd_rt_M: W.wa==M.rt && rf_wr_W && wa_W≠0.
  - Register 0 never stalls and never forwards.
- Latency: the D decode is visible on the E outputs 1 cycle later, M 2 cycles later, W 3 cycles later, absent a stall.
- Reset:
  - All E/M/W registers clear to the bubble; every registered output is 0 in the cycle after reset asserts.
  - Reset asserted during a stall discards the in-flight bundles; stall then depends only on instr_D against the empty pipe, i.e. stall = 0.
- Simultaneous hazards on rs and rt OR together into a single stall.
- Stall persists for as many cycles as required (e.g. lw→beq: 2 cycles).

Test Plan:
- Load-use: lw $8,0($0) then addu $9,$8,$8 → stall=1 for exactly 1 cycle, E bubble; next cycle fwd_rs_E=fwd_rt_E=2 (W).
- Load-branch: lw $8 then beq $8,$0 → stall for 2 cycles; then fwd_rs_D=0 (RF bypass).
- ALU→ALU: addu $3,$1,$2; subu $4,$3,$3 → no stall; fwd_rs_E=fwd_rt_E=1 (M), alu_op_E=1.
- jal then jr $31 → no stall; fwd_rs_D=1 (E) in cycle 1; wa_W=31 and wd_sel_W=2 three cycles after jal enters D.
- Writes to $0 (ori $0,$0,5) followed by a reader of $0 → stall=0, all fwd=0; with EN_SLT=0, slt produces rf_wr_W=0.
- Reset asserted while lw→beq stall is active → next cycle stall=0 and rf_wr_W=dm_wr_M=0, all fwd=0.
